// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard of in-flight destinations (one slot per post-ID stage) driving forwarding selects and load-use stall.
// Latency: selects/stall are combinational from registered slots; no backpressure input, it only issues the stall.
module hazard_scoreboard_unit #(
    parameter int REG_W      = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rf_enable,
    input  logic             id_load,
    input  logic             id_flush,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic             stall,
    output logic             pc_le,
    output logic             ifid_le,
    output logic             ctrl_bubble,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             rf_en;
        logic             load;
    } slot_t;

    slot_t            slots [STAGES];
    logic [SEL_W-1:0] sel_a_raw, sel_b_raw;
    logic             haz_a, haz_b, stall_int;

    // Scan oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        sel_a_raw = '0;
        sel_b_raw = '0;
        haz_a     = 1'b0;
        haz_b     = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (slots[k].valid && slots[k].rf_en && slots[k].rd == id_rs) begin
                haz_a     = slots[k].load && (k < LOAD_READY);
                sel_a_raw = haz_a ? '0 : SEL_W'(k + 1);
            end
            if (slots[k].valid && slots[k].rf_en && slots[k].rd == id_rt) begin
                haz_b     = slots[k].load && (k < LOAD_READY);
                sel_b_raw = haz_b ? '0 : SEL_W'(k + 1);
            end
        end
        if (!id_use_rs || id_rs == '0) begin
            sel_a_raw = '0;
            haz_a     = 1'b0;
        end
        if (!id_use_rt || id_rt == '0) begin
            sel_b_raw = '0;
            haz_b     = 1'b0;
        end
    end

    assign stall_int = id_valid && !id_flush && (haz_a || haz_b);

    always_comb begin
        fwd_sel_a   = '0;
        fwd_sel_b   = '0;
        stall       = 1'b0;
        pc_le       = 1'b1;
        ifid_le     = 1'b1;
        ctrl_bubble = 1'b1;
        if (!reset) begin
            fwd_sel_a   = sel_a_raw;
            fwd_sel_b   = sel_b_raw;
            stall       = stall_int;
            pc_le       = !stall_int;
            ifid_le     = !stall_int;
            ctrl_bubble = stall_int || id_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) slots[k] <= '0;
            stall_count <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++) slots[k] <= slots[k-1];
            // A stalled or squashed ID instruction enters EX as an empty slot.
            if (stall_int || id_flush) slots[0] <= '0;
            else                       slots[0] <= {id_valid, id_rd, id_rf_enable, id_load};
            if (stall_int && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench: default instance (3 stages, load ready at MEM) and a swept instance (4 stages, load ready at slot 2).
// Both share stimulus; table vectors, a mid-stall reset sequence and a randomized run against a reference model.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       reset, id_valid, id_use_rs, id_use_rt, id_rf_enable, id_load, id_flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic [1:0]  sa0, sb0;
    logic [2:0]  sa1, sb1;
    logic        st0, pc0, if0, bub0, st1, pc1, if1, bub1;
    logic [15:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_rf_enable(id_rf_enable),
        .id_load(id_load), .id_flush(id_flush), .fwd_sel_a(sa0), .fwd_sel_b(sb0), .stall(st0),
        .pc_le(pc0), .ifid_le(if0), .ctrl_bubble(bub0), .stall_count(cnt0)
    );

    hazard_scoreboard_unit #(.STAGES(4), .LOAD_READY(2), .SEL_W(3)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_rf_enable(id_rf_enable),
        .id_load(id_load), .id_flush(id_flush), .fwd_sel_a(sa1), .fwd_sel_b(sb1), .stall(st1),
        .pc_le(pc1), .ifid_le(if1), .ctrl_bubble(bub1), .stall_count(cnt1)
    );

    typedef struct {
        bit rst; bit v; logic [4:0] rs; logic [4:0] rt; bit urs; bit urt;
        logic [4:0] rd; bit rf; bit ld; bit fl;
        int sa; int sb; bit st; bit pc; bit bub; int cnt;
    } vec_t;

    typedef struct packed { logic v; logic [4:0] rd; logic rf; logic ld; } ent_t;

    ent_t hist [2][4];
    int   stg  [2] = '{3, 4};
    int   lrdy [2] = '{1, 2};
    int   mcnt [2];

    function automatic vec_t mk(bit rst, bit v, int rs, int rt, bit urs, bit urt, int rd, bit rf,
                                bit ld, bit fl, int sa, int sb, bit st, bit pc, bit bub, int cnt);
        vec_t x;
        x.rst = rst; x.v = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
        x.rd = 5'(rd); x.rf = rf; x.ld = ld; x.fl = fl;
        x.sa = sa; x.sb = sb; x.st = st; x.pc = pc; x.bub = bub; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t x);
        reset = x.rst; id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs;
        id_use_rt = x.urt; id_rd = x.rd; id_rf_enable = x.rf; id_load = x.ld; id_flush = x.fl;
    endtask

    task automatic check_dut(input int d, input string tag, input int sa, input int sb, input bit st,
                             input bit pc, input bit bub, input int cnt);
        if (d == 0) begin
            chk({tag, ".sel_a"}, 32'(sa0), sa);   chk({tag, ".sel_b"}, 32'(sb0), sb);
            chk({tag, ".stall"}, 32'(st0), 32'(st)); chk({tag, ".pc_le"}, 32'(pc0), 32'(pc));
            chk({tag, ".ifid_le"}, 32'(if0), 32'(pc)); chk({tag, ".bubble"}, 32'(bub0), 32'(bub));
            chk({tag, ".count"}, 32'(cnt0), cnt);
        end else begin
            chk({tag, ".sel_a"}, 32'(sa1), sa);   chk({tag, ".sel_b"}, 32'(sb1), sb);
            chk({tag, ".stall"}, 32'(st1), 32'(st)); chk({tag, ".pc_le"}, 32'(pc1), 32'(pc));
            chk({tag, ".ifid_le"}, 32'(if1), 32'(pc)); chk({tag, ".bubble"}, 32'(bub1), 32'(bub));
            chk({tag, ".count"}, 32'(cnt1), cnt);
        end
    endtask

    task automatic reset_cycle();
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        @(posedge clk); #1;
    endtask

    // Nearest producer among the tracked instructions decides; a too-young load is a hazard.
    task automatic lookup(input int d, input bit use_r, input logic [4:0] r, output int sel, output bit hz);
        bit found = 0;
        sel = 0; hz = 0;
        if (use_r && r != 0) begin
            for (int k = 0; k < stg[d]; k++) begin
                if (!found && hist[d][k].v && hist[d][k].rf && hist[d][k].rd == r) begin
                    found = 1;
                    if (hist[d][k].ld && k < lrdy[d]) hz = 1;
                    else sel = k + 1;
                end
            end
        end
    endtask

    task automatic model(input int d, input vec_t x, output int sa, output int sb, output bit st,
                         output bit pc, output bit bub);
        bit ha, hb;
        lookup(d, x.urs, x.rs, sa, ha);
        lookup(d, x.urt, x.rt, sb, hb);
        st = x.v && !x.fl && (ha || hb);
        if (x.rst) begin
            sa = 0; sb = 0; st = 0; pc = 1; bub = 1;
        end else begin
            pc = !st; bub = st || x.fl;
        end
    endtask

    task automatic advance(input int d, input vec_t x, input bit st);
        if (x.rst) begin
            for (int k = 0; k < 4; k++) hist[d][k] = '0;
            mcnt[d] = 0;
        end else begin
            if (st && mcnt[d] < 65535) mcnt[d]++;
            for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = (st || x.fl) ? ent_t'('0) : {x.v, x.rd, x.rf, x.ld};
        end
    endtask

    vec_t ta [22];
    vec_t tb [6];

    initial begin
        //        rst v rs rt urs urt rd rf ld fl | sa sb st pc bub cnt
        ta[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        ta[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        ta[2]  = mk(0, 1, 3, 0, 1, 0, 8, 1, 0, 0,  0, 0, 0, 1, 0, 0);
        ta[3]  = mk(0, 1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 1, 0, 0);
        ta[4]  = mk(0, 1, 5, 0, 1, 0, 9, 1, 0, 0,  1, 0, 0, 1, 0, 0);
        ta[5]  = mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0);
        ta[6]  = mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0);
        ta[7]  = mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        ta[8]  = mk(0, 1, 0, 0, 1, 0, 4, 1, 1, 0,  0, 0, 0, 1, 0, 0);
        ta[9]  = mk(0, 1, 4, 4, 1, 1, 10, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        ta[10] = mk(0, 1, 4, 4, 1, 1, 10, 1, 0, 0, 2, 2, 0, 1, 0, 1);
        ta[11] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 1, 0, 1);
        ta[12] = mk(0, 1, 0, 0, 1, 0, 7, 1, 0, 0,  0, 0, 0, 1, 0, 1);
        ta[13] = mk(0, 1, 7, 7, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1, 0, 1);
        ta[14] = mk(0, 1, 0, 7, 1, 1, 0, 0, 0, 0,  0, 2, 0, 1, 0, 1);
        ta[15] = mk(0, 1, 7, 7, 1, 0, 0, 0, 0, 0,  3, 0, 0, 1, 0, 1);
        ta[16] = mk(0, 1, 0, 0, 1, 0, 2, 1, 1, 0,  0, 0, 0, 1, 0, 1);
        ta[17] = mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 1);
        ta[18] = mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 1);
        ta[19] = mk(0, 1, 0, 0, 1, 0, 3, 1, 1, 0,  0, 0, 0, 1, 0, 1);
        ta[20] = mk(0, 0, 3, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1);
        ta[21] = mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 1);

        tb[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
        tb[1]  = mk(0, 1, 0, 0, 1, 0, 4, 1, 1, 0,  0, 0, 0, 1, 0, 0);
        tb[2]  = mk(0, 1, 4, 0, 1, 0, 10, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        tb[3]  = mk(0, 1, 4, 0, 1, 0, 10, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        tb[4]  = mk(0, 1, 4, 0, 1, 0, 10, 1, 0, 0, 3, 0, 0, 1, 0, 2);
        tb[5]  = mk(0, 1, 0, 0, 1, 0, 6, 1, 1, 0,  0, 0, 0, 1, 0, 2);

        reset_cycle();
        foreach (ta[i]) begin
            apply(ta[i]); #2;
            check_dut(0, $sformatf("tabA[%0d]", i), ta[i].sa, ta[i].sb, ta[i].st, ta[i].pc, ta[i].bub, ta[i].cnt);
            @(posedge clk); #1;
        end

        reset_cycle();
        foreach (tb[i]) begin
            apply(tb[i]); #2;
            check_dut(1, $sformatf("tabB[%0d]", i), tb[i].sa, tb[i].sb, tb[i].st, tb[i].pc, tb[i].bub, tb[i].cnt);
            @(posedge clk); #1;
        end

        // Reader of the fresh load stalls, then reset lands in that first stall cycle.
        apply(mk(0, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
        check_dut(1, "midB.stall", 0, 0, 1, 0, 1, 2);
        reset = 1'b1; #1;
        check_dut(1, "midB.rst", 0, 0, 0, 1, 1, 2);
        @(posedge clk); #1;
        apply(mk(0, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
        check_dut(1, "midB.after", 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;

        reset_cycle();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) hist[d][k] = '0;
            mcnt[d] = 0;
        end
        for (int n = 0; n < 600; n++) begin
            vec_t x;
            int   sa, sb;
            bit   st [2];
            bit   pc, bub;
            x = mk(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                   0, 0, 0, 0, 0, 0);
            apply(x); #2;
            for (int d = 0; d < 2; d++) begin
                model(d, x, sa, sb, st[d], pc, bub);
                check_dut(d, $sformatf("rnd%0d[%0d]", d, n), sa, sb, st[d], pc, bub, mcnt[d]);
            end
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) advance(d, x, st[d]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
